mem_stream_reader: RTL and testbench

//  Initiator on one port of the shared word-addressed dual-port RAM: fetches LENGTH consecutive
//  32-bit words starting at a word address and emits them as a valid/ready stream (e.g. toward
//  the NoC packet injector). Never writes memory. Hides the RAM's 1-cycle registered read latency

---
 rtl/pkt_mem_pkg.sv | 22 ++
 rtl/stream_fifo.sv | 70 +++++++
 rtl/mem_stream_reader.sv | 158 +++++++++++++++
 tb/tb_mem_stream_reader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_mem_pkg.sv
// Shared types and constants for the memory stream reader.
//   reader_state_t : reader FSM states
//   MEM_WB_NONE    : byte strobes driven on a read-only RAM port
//   DATA_WIDTH     : RAM word width
//   cnt_width()    : bits needed to hold an occupancy count of 0..depth
package pkt_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } reader_state_t;

    localparam logic [3:0]  MEM_WB_NONE = 4'b0000;
    localparam int unsigned DATA_WIDTH  = 32;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO buffering words read from RAM until the sink takes them.
// Ports:
//   i_clock, i_reset     clock, asynchronous active-high reset
//   i_flush              synchronous clear of all entries
//   i_push, i_push_data  write one word (ignored when full unless popping)
//   i_pop                remove head word (ignored when empty)
//   o_head               current head word
//   o_count              entries held, 0..DEPTH
//   o_full, o_empty      occupancy flags
module stream_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    // Pointers and occupancy.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only entries below r_count are ever observed.
    always_ff @(posedge i_clock) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/mem_stream_reader.sv
// Reads LENGTH consecutive words from a RAM port and streams them out valid/ready.
// Ports:
//   i_clock, i_reset            clock, asynchronous active-high reset
//   i_start, i_base_addr,
//   i_length                    transfer request, sampled in IDLE only
//   i_abort                     cancel an active transfer (no done pulse)
//   o_busy, o_done              transfer active / one-cycle completion pulse
//   o_mem_enable, o_mem_addr,
//   o_mem_wb, o_mem_wdata       RAM port controls (read only)
//   i_mem_rdata                 RAM data, valid the cycle after an address issue
//   o_tx_data, o_tx_valid,
//   i_tx_ready                  output stream
module mem_stream_reader
    import pkt_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [LEN_WIDTH-1:0]  i_length,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_enable,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [3:0]            o_mem_wb,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready
);

    localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);
    localparam int unsigned CRD_W = CNT_W + 1;

    reader_state_t         r_state;
    reader_state_t         w_next_state;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_rd_pending;

    logic [CNT_W-1:0]      w_fifo_count;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_active;
    logic                  w_cancel;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_fifo_drains;
    logic [CRD_W-1:0]      w_in_flight;

    assign w_active = (r_state == RUN) || (r_state == DRAIN);
    assign w_cancel = w_active && i_abort;
    assign w_accept = (r_state == IDLE) && i_start;
    assign w_pop    = o_tx_valid && i_tx_ready;
    // Only a read issued on the previous edge returns data worth keeping.
    assign w_push   = r_rd_pending && !w_cancel;

    // Words already committed to the FIFO: buffered plus in flight, minus the one leaving now.
    assign w_in_flight = CRD_W'(w_fifo_count) + CRD_W'(r_rd_pending) - CRD_W'(w_pop);
    assign w_issue     = (r_state == RUN) && !i_abort && (r_remaining != '0)
                         && (w_in_flight < CRD_W'(FIFO_DEPTH)) && (!w_fifo_full || w_pop);
    assign w_last_issue = w_issue && (r_remaining == LEN_WIDTH'(1));
    // The head leaving this cycle counts, so done follows the last handshake directly.
    assign w_fifo_drains = !r_rd_pending
                           && (w_fifo_empty || ((w_fifo_count == CNT_W'(1)) && w_pop));

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) w_next_state = (i_length != '0) ? RUN : FINISH;
            end
            RUN: begin
                if (i_abort)           w_next_state = IDLE;
                else if (w_last_issue) w_next_state = DRAIN;
            end
            DRAIN: begin
                if (i_abort)            w_next_state = IDLE;
                else if (w_fifo_drains) w_next_state = FINISH;
            end
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            RUN, DRAIN: o_busy = 1'b1;
            FINISH:     o_done = 1'b1;
            default:    ;
        endcase
    end

    // Address/length counters and the outstanding-read flag.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cur_addr   <= '0;
            r_remaining  <= '0;
            r_mem_addr   <= '0;
            r_rd_pending <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cur_addr  <= i_base_addr;
                r_remaining <= i_length;
            end else if (w_issue) begin
                r_mem_addr  <= r_cur_addr;
                r_cur_addr  <= r_cur_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - LEN_WIDTH'(1);
            end
            // Capture clears the flag; an overlapping issue keeps it set.
            r_rd_pending <= w_issue;
        end
    end

    stream_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_flush     (w_cancel),
        .i_push      (w_push),
        .i_push_data (i_mem_rdata),
        .i_pop       (w_pop),
        .o_head      (o_tx_data),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign o_tx_valid   = !w_fifo_empty;
    assign o_mem_addr   = r_mem_addr;
    // The port is enabled for as long as the block is out of reset.
    assign o_mem_enable = !i_reset;
    assign o_mem_wb     = MEM_WB_NONE;
    assign o_mem_wdata  = '0;

endmodule

// File: tb/tb_mem_stream_reader.sv
module tb_mem_stream_reader;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        abort;
    logic        busy;
    logic        done;
    logic        mem_enable;
    logic [15:0] mem_addr;
    logic [3:0]  mem_wb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    logic [31:0] ram [0:65535];
    logic [15:0] addr_log [$];
    int          total = 0;
    int          bad = 0;
    int          wb_bad = 0;

    always #5 clk = ~clk;

    // Behavioural RAM: data for the registered address is visible the cycle after it is loaded.
    assign mem_rdata = ram[mem_addr];

    mem_stream_reader #(
        .ADDR_WIDTH (16),
        .LEN_WIDTH  (16),
        .FIFO_DEPTH (DEPTH)
    ) u_dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_length    (length),
        .i_abort     (abort),
        .o_busy      (busy),
        .o_done      (done),
        .o_mem_enable(mem_enable),
        .o_mem_addr  (mem_addr),
        .o_mem_wb    (mem_wb),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready)
    );

    always @(negedge clk) begin
        if (mem_wb !== 4'b0000 || mem_wdata !== 32'd0) wb_bad++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Runs one transfer and checks it against the word list derived from the RAM image.
    // mode 0: sink always ready, 1: ready every other cycle, 2: random ready.
    // exp_first / exp_done: expected cycle index (0 = cycle after start edge), -2 = skip.
    task automatic run_xfer(input logic [15:0] b, input int len, input int mode,
                            input int exp_first, input int exp_done, input string tag);
        logic [31:0] expq [$];
        logic [31:0] prev_data;
        logic [15:0] last_addr;
        logic        prev_stall;
        int cyc, first_v, last_hs, done_cyc, issues, acc, viol, busy_bad;
        for (int i = 0; i < len; i++) expq.push_back(ram[16'(b + 16'(i))]);
        addr_log.delete();
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = 16'(len);
        last_addr = mem_addr;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; first_v = -1; last_hs = -1; done_cyc = -1;
        issues = 0; acc = 0; viol = 0; busy_bad = 0; prev_stall = 1'b0; prev_data = '0;
        while (done_cyc < 0 && cyc < 4 * len + 40) begin
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 2 == 0);
                default: tx_ready = ($urandom_range(0, 2) != 0);
            endcase
            @(negedge clk);
            if (mem_addr !== last_addr) begin
                issues++;
                last_addr = mem_addr;
                addr_log.push_back(mem_addr);
            end
            if (prev_stall) begin
                chk({tag, " stall_valid"}, 32'(tx_valid), 32'd1);
                chk({tag, " stall_data"}, tx_data, prev_data);
            end
            if (tx_valid && first_v < 0) first_v = cyc;
            if (issues - acc > int'(DEPTH)) viol++;
            if (tx_valid && tx_ready) begin
                if (expq.size() > 0) chk({tag, " word"}, tx_data, expq.pop_front());
                acc++;
                last_hs = cyc;
            end
            if (done) done_cyc = cyc;
            if (busy !== ((len != 0) && done_cyc < 0)) busy_bad++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " word_count"}, 32'(acc), 32'(len));
        chk({tag, " busy_profile"}, 32'(busy_bad), 32'd0);
        chk({tag, " fifo_bound"}, 32'(viol), 32'd0);
        if (len != 0) chk({tag, " done_after_last"}, 32'(done_cyc), 32'(last_hs + 1));
        else          chk({tag, " no_reads"}, 32'(issues), 32'd0);
        if (exp_first != -2) chk({tag, " first_valid"}, 32'(first_v), 32'(exp_first));
        if (exp_done != -2)  chk({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
        @(negedge clk);
        chk({tag, " done_pulse_end"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [15:0] base;
        int          len;
        int          mode;
        int          exp_first;
        int          exp_done;
    } vec_t;

    initial begin
        vec_t        vecs [5];
        logic [15:0] wrap_exp [4];
        int          hs, cyc, dcnt, vcnt;

        for (int a = 0; a < 65536; a++) ram[16'(a)] = $urandom;
        for (int a = 0; a < 4; a++) ram[16'h0100 + 16'(a)] = 32'(a + 1);

        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; abort = 1'b0; tx_ready = 1'b1;
        #3;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst tx_valid", 32'(tx_valid), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst mem_enable", 32'(mem_enable), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mem_enable", 32'(mem_enable), 32'd1);

        vecs[0] = '{16'h0100, 4, 0, 2, 6};
        vecs[1] = '{16'h0100, 4, 1, 2, -2};
        vecs[2] = '{16'hFFFE, 4, 0, 2, 6};
        vecs[3] = '{16'h0050, 0, 0, -2, 0};
        vecs[4] = '{16'h1234, 9, 0, 2, 11};
        wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF; wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;

        for (int v = 0; v < 5; v++) begin
            run_xfer(vecs[v].base, vecs[v].len, vecs[v].mode,
                     vecs[v].exp_first, vecs[v].exp_done, $sformatf("vec%0d", v));
            if (v == 2) begin
                chk("wrap addr_count", 32'(addr_log.size()), 32'd4);
                for (int k = 0; k < 4 && k < addr_log.size(); k++)
                    chk($sformatf("wrap addr%0d", k), 32'(addr_log[k]), 32'(wrap_exp[k]));
            end
        end

        // Abort after five accepted words, then a fresh short transfer.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 16'h0300; length = 16'd16; tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hs = 0; cyc = 0;
        while (hs < 5 && cyc < 100) begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                chk("abort word", tx_data, ram[16'h0300 + 16'(hs)]);
                hs++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort words_before", 32'(hs), 32'd5);
        tx_ready = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; tx_ready = 1'b1;
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort tx_valid", 32'(tx_valid), 32'd0);
        dcnt = 0; vcnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) dcnt++;
            if (tx_valid) vcnt++;
        end
        chk("abort no_done", 32'(dcnt), 32'd0);
        chk("abort no_valid", 32'(vcnt), 32'd0);
        run_xfer(16'h0200, 2, 0, 2, 4, "post_abort");

        // Stalled sink fills the FIFO; reset mid-transfer.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 16'h0400; length = 16'd8; tx_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("stall last_addr", 32'(mem_addr), 32'h0403);
        chk("stall tx_valid", 32'(tx_valid), 32'd1);
        chk("stall head", tx_data, ram[16'h0400]);
        chk("stall busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst tx_valid", 32'(tx_valid), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst mem_addr", 32'(mem_addr), 32'd0);
        chk("midrst mem_enable", 32'(mem_enable), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; tx_ready = 1'b1;
        run_xfer(16'h0100, 4, 0, 2, 6, "post_reset");

        // Random transfers against the RAM-image model.
        for (int r = 0; r < 20; r++) begin
            logic [15:0] rb;
            int rl, rm;
            rb = 16'($urandom_range(0, 65535));
            rl = int'($urandom_range(0, 12));
            rm = ($urandom_range(0, 1) == 0) ? 0 : 2;
            run_xfer(rb, rl, rm, (rl == 0) ? -2 : 2,
                     (rl == 0) ? 0 : ((rm == 0) ? rl + 2 : -2), $sformatf("rnd%0d", r));
        end

        chk("mem_wb_wdata_zero", 32'(wb_bad), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
